// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder FSM and its storage array.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefLatency   = 2;
  localparam int unsigned LaneW        = 8;
  localparam int unsigned NumLanes     = 4;
  localparam int unsigned CntW         = 4;

  function automatic logic addr_fault(
    input logic [31:0] addr,
    input int unsigned aw
  );
    return (addr[1:0] != 2'b00) ||
           ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed byte-enable register array with combinational read
// and asynchronous clear.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (be_i[l]) begin
          mem_q[addr_i][l*LaneW +: LaneW] <=
            wdata_i[l*LaneW +: LaneW];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one access at a time,
// fixed latency, registered response held until accepted.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned LATENCY    = DefLatency
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              fault;
  logic [31:0]       mem_rdata;

  assign fault = addr_fault(addr_q, ADDR_WIDTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Faulting stores must never reach the array.
          mem_we  = write_q & ~fault;
          err_d   = fault;
          rdata_d = (write_q | fault) ? 32'd0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .addr_i  (addr_q[ADDR_WIDTH+1:2]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (mem_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM stage's data-memory interface.
- Accepts one load or store request at a time over a valid/ready handshake and performs the access after a fixed number of cycles.
- Returns a response (read data or store acknowledge) over a valid/ready handshake. The MEM stage holds the pipeline until the response arrives.
- Replaces the single-cycle data memory so that memory latency is modelled explicitly.

Parameters:
- ADDR_WIDTH, 8, word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request acceptance to the response becoming valid; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (the ALU result).
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers byte lane i (bits 8i+7:8i).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and on error.
- resp_error  out  1  access faulted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
  - Latency counter cleared; every memory word set to 0.
  - Reset asserted mid-access aborts the access: no write occurs and no response is produced.
- States and transitions:
  - IDLE: req_ready=1. On a rising edge with req_valid=1, the request is accepted. req_write, req_addr, req_wdata and req_be are latched, the counter is loaded with LATENCY-1, and the state moves to ACCESS.
  - ACCESS: req_ready=0. The counter decrements every cycle. On the edge where the counter is 0, the access is performed, resp_rdata and resp_error are registered, and the state moves to RESP.
  - RESP: resp_valid=1 and resp_rdata/resp_error are held stable. On an edge with resp_ready=1, the state returns to IDLE and resp_valid drops.
  - resp_ready is ignored outside RESP.
  - req_valid is ignored outside IDLE; the requester must hold its request until it sees req_ready=1.
- Latency and throughput:
  - Request accepted at edge t → resp_valid=1 after edge t+LATENCY.
  - With resp_ready tied to 1, the next request is accepted at edge t+LATENCY+2. Back-to-back throughput is one access per LATENCY+2 cycles.
- Addressing and errors:
  - Word index = latched addr[ADDR_WIDTH+1:2].
  - Misaligned: addr[1:0] != 0 → error.
  - Out of range: addr[31:ADDR_WIDTH+2] != 0 → error.
  - On error: resp_error=1, resp_rdata=0, no memory write.
- Stores:
  - Only lanes with req_be[i]=1 are updated; other lanes keep their value.
  - be=0000 is a legal no-op store and still returns a response with resp_error=0.
  - resp_rdata=0 for stores.
- Loads return the full 32-bit word; req_be is ignored.
- Ordering: a load after a store to the same address returns the stored data, because accesses are strictly serialised.
- Data-path rule: memory contents change only on the final ACCESS edge, never in IDLE or RESP.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - default ADDR_WIDTH and LATENCY;
  - byte-lane width constant 8.
- One sub-module is natural: dmem_array. It is a synchronous write-enable, byte-enable register array with combinational read and asynchronous active-low clear.
- dmem_responder owns the FSM, latency counter, request latch and error check.

Test Plan:
1. Store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 → store response has error=0, rdata=0; load resp_rdata=0xDEADBEEF; each resp_valid arrives exactly LATENCY cycles after acceptance.
2. Preload 0x11223344 at 0x20, then store 0xAABBCCDD with be=0101, then load 0x20 → 0x11BB33DD.
3. Load from 0x22 (misaligned), then store to 0x400 with ADDR_WIDTH=8 (out of range) → both give resp_error=1 and resp_rdata=0; a subsequent load of 0x0 returns 0, proving no write occurred.
4. Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 with a new request → resp_valid and resp_rdata stay stable, req_ready=0 throughout, and no second acceptance; after resp_ready=1 the new request is accepted one cycle later.
5. Assert reset during ACCESS of a store 0x12345678 to 0x8 → outputs return immediately to their reset values, no response is produced, and a later load of 0x8 returns 0.
6. Run with LATENCY=1 and resp_ready tied to 1 over 4 back-to-back loads → each resp_valid is high for one cycle; acceptances occur every 3 cycles.
